// File: rtl/pim_instr_issue.sv
// PIM instruction issue stage: host words are queued in a FIFO and presented one at a time
// with a load strobe; issue waits for exec_busy, and a HALT opcode parks the stage until resume.

// Generic single-clock FIFO. Data is visible at the head the cycle after it is pushed.
// The caller must not push when full or pop when empty.
module pim_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    if (push_i && !pop_i) count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdat_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// Issue FSM: one-cycle LOAD per popped word, so at most one issue every two cycles.
// Host is backpressured by FIFO occupancy only; issue is held off by exec_busy and HALT.
module pim_instr_issue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              host_instr,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     exec_busy,
  input  logic                     resume,
  output logic [63:0]              PIM_instr,
  output logic                     PIM_load,
  output logic [15:0]              instr_type,
  output logic [3:0]               CW_opcode,
  output logic [3:0]               mov_dest_bin,
  output logic [3:0]               mov_src_bin,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         issued_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  OP_MOV   = 4'h1;
  localparam logic [3:0]  OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_WAIT   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [63:0]      head;
  logic [AW:0]      count;
  logic             push;
  logic             pop;
  logic             issue;

  logic [63:0]      instr_q, instr_d;
  logic [15:0]      type_q, type_d;
  logic [3:0]       dest_q, dest_d;
  logic [3:0]       src_q, src_d;
  logic [CNT_W-1:0] issued_q, issued_d;

  // Ready is based on the registered count, so a full FIFO refuses a push even on a pop cycle.
  assign host_ready = (count < FULL_CNT);
  assign push       = host_valid && host_ready;

  pim_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdat_i  (host_instr),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if ((count != '0) && !exec_busy) begin
          pop = 1'b1;
          if (head[3:0] == OP_HALT) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_LOAD;
            issue   = 1'b1;
          end
        end else if ((state_q == S_WAIT) && (count == '0)) begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:   state_d = S_WAIT;
      S_HALTED: if (resume) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_d  = instr_q;
    type_d   = type_q;
    dest_d   = dest_q;
    src_d    = src_q;
    issued_d = issued_q;
    if (issue) begin
      instr_d = head;
      type_d  = 16'h0001 << head[3:0];
      if (head[3:0] == OP_MOV) begin
        dest_d = head[7:4];
        src_d  = head[11:8];
      end
    end
    if (state_q == S_LOAD) issued_d = issued_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      type_q   <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      type_q   <= type_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      issued_q <= issued_d;
    end
  end

  assign PIM_instr    = instr_q;
  assign PIM_load     = (state_q == S_LOAD);
  assign halted       = (state_q == S_HALTED);
  assign CW_opcode    = ((state_q == S_LOAD) && (instr_q[3:0] == OP_MOV)) ? 4'b0001 : 4'b0000;
  assign instr_type   = type_q;
  assign mov_dest_bin = dest_q;
  assign mov_src_bin  = src_q;
  assign fifo_count   = count;
  assign issued_count = issued_q;
endmodule

// File: tb/tb_pim_instr_issue.sv
// Randomised and directed bench for pim_instr_issue, checked every cycle against a queue-based model.
module tb_pim_instr_issue;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [63:0]      host_instr = '0;
  logic             host_valid = 1'b0;
  logic             exec_busy = 1'b0;
  logic             resume = 1'b0;
  logic             host_ready;
  logic [63:0]      PIM_instr;
  logic             PIM_load;
  logic [15:0]      instr_type;
  logic [3:0]       CW_opcode;
  logic [3:0]       mov_dest_bin;
  logic [3:0]       mov_src_bin;
  logic             halted;
  logic [FW-1:0]    fifo_count;
  logic [CNT_W-1:0] issued_count;

  pim_instr_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_instr   (host_instr),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .exec_busy    (exec_busy),
    .resume       (resume),
    .PIM_instr    (PIM_instr),
    .PIM_load     (PIM_load),
    .instr_type   (instr_type),
    .CW_opcode    (CW_opcode),
    .mov_dest_bin (mov_dest_bin),
    .mov_src_bin  (mov_src_bin),
    .halted       (halted),
    .fifo_count   (fifo_count),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: a queue of pending words plus "loading" and "halted" flags.
  logic [63:0]      mq[$];
  bit               m_load;
  bit               m_halt;
  logic [63:0]      m_instr;
  logic [15:0]      m_type;
  logic [3:0]       m_dest;
  logic [3:0]       m_src;
  logic [CNT_W-1:0] m_issued;
  logic [CNT_W-1:0] prev_issued;
  logic             wrap_seen;

  task automatic model_reset();
    mq.delete();
    m_load   = 0;
    m_halt   = 0;
    m_instr  = '0;
    m_type   = '0;
    m_dest   = '0;
    m_src    = '0;
    m_issued = '0;
  endtask

  task automatic model_step(input logic v, input logic [63:0] w, input logic b, input logic r);
    logic        room;
    logic [63:0] h;
    room = (mq.size() < DEPTH);
    if (m_load) m_issued = m_issued + 1'b1;
    if (m_halt) begin
      if (r) m_halt = 0;
    end else if (m_load) begin
      m_load = 0;
    end else if (mq.size() > 0 && !b) begin
      h = mq.pop_front();
      if (h[3:0] == 4'hF) begin
        m_halt = 1;
      end else begin
        m_load  = 1;
        m_instr = h;
        m_type  = '0;
        m_type[h[3:0]] = 1'b1;
        if (h[3:0] == 4'h1) begin
          m_dest = h[7:4];
          m_src  = h[11:8];
        end
      end
    end
    if (v && room) mq.push_back(w);
  endtask

  task automatic check_all();
    chk("pim_load",   PIM_load,     m_load);
    chk("halted",     halted,       m_halt);
    chk("fifo_count", fifo_count,   mq.size());
    chk("host_ready", host_ready,   mq.size() < DEPTH);
    chk("pim_instr",  PIM_instr,    m_instr);
    chk("instr_type", instr_type,   m_type);
    chk("cw_opcode",  CW_opcode,    (m_load && m_instr[3:0] == 4'h1) ? 4'h1 : 4'h0);
    chk("mov_dest",   mov_dest_bin, m_dest);
    chk("mov_src",    mov_src_bin,  m_src);
    chk("issued",     issued_count, m_issued);
    if (issued_count == '0 && prev_issued == '1) wrap_seen = 1'b1;
    prev_issued = issued_count;
  endtask

  task automatic cycle(input logic v, input logic [63:0] w, input logic b, input logic r);
    host_valid = v;
    host_instr = w;
    exec_busy  = b;
    resume     = r;
    @(posedge clk);
    model_step(v, w, b, r);
    #1;
    check_all();
  endtask

  function automatic logic [63:0] rand_word(input logic [3:0] op);
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    w[3:0] = op;
    return w;
  endfunction

  logic [63:0] fill_w[DEPTH];
  int          loads;
  logic [63:0] w2;

  initial begin
    model_reset();
    prev_issued = '0;
    wrap_seen   = 1'b0;

    // Reset state
    #1;
    check_all();
    chk("rst_ready", host_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Single word: pop one edge after push, one LOAD cycle
    cycle(1, 64'h8, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t1_load", PIM_load, 1);
    chk("t1_type", instr_type, 16'h0100);
    cycle(0, 0, 0, 0);
    chk("t1_load_off", PIM_load, 0);
    chk("t1_issued", issued_count, 1);
    chk("t1_fifo", fifo_count, 0);

    // MOV selects and CW opcode
    cycle(1, 64'h391, 0, 0);
    cycle(0, 0, 0, 0);
    chk("mov_cw", CW_opcode, 4'b0001);
    chk("mov_dest_d", mov_dest_bin, 9);
    chk("mov_src_d", mov_src_bin, 3);
    cycle(0, 0, 0, 0);
    chk("mov_cw_off", CW_opcode, 0);
    chk("mov_dest_hold", mov_dest_bin, 9);
    chk("mov_src_hold", mov_src_bin, 3);

    // Fill under exec_busy, 9th push refused, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      fill_w[i] = rand_word(4'(i + 2));
      cycle(1, fill_w[i], 1, 0);
    end
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready", host_ready, 0);
    cycle(1, rand_word(4'h3), 1, 0);
    chk("full_refused", fifo_count, DEPTH);
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0);
      if (PIM_load) begin
        if (loads < DEPTH) chk("fill_order", PIM_instr, fill_w[loads]);
        loads++;
      end
    end
    chk("fill_loads", loads, DEPTH);

    // HALT parks issue until resume
    w2 = 64'hABCD_0000_0000_0052;
    cycle(1, 64'h0000_0000_0000_00AF, 0, 0);
    cycle(1, w2, 0, 0);
    chk("halt_on", halted, 1);
    chk("halt_noload", PIM_load, 0);
    chk("halt_fifo", fifo_count, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    chk("halt_hold", halted, 1);
    cycle(0, 0, 0, 1);
    chk("resume_off", halted, 0);
    chk("resume_noload", PIM_load, 0);
    cycle(0, 0, 0, 0);
    chk("resume_load", PIM_load, 1);
    chk("resume_type", instr_type, 16'h0004);
    chk("resume_instr", PIM_instr, w2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

    // Asynchronous reset during LOAD with three words queued
    for (int i = 0; i < 4; i++) cycle(1, rand_word(4'h5), 1, 0);
    cycle(0, 0, 0, 0);
    chk("pre_rst_load", PIM_load, 1);
    chk("pre_rst_fifo", fifo_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_load", PIM_load, 0);
    chk("arst_fifo", fifo_count, 0);
    chk("arst_issued", issued_count, 0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);

    // Sustained pushes until the issue counter wraps
    for (int i = 0; i < 700; i++) cycle(1, rand_word(4'($urandom_range(0, 14))), 0, 0);
    chk("issued_wrap", wrap_seen, 1);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      cycle($urandom_range(0, 99) < 55, rand_word(op),
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
